// File: rtl/ofifo_pkg.sv
// Shared widths and helpers for the ofifo_multi output FIFO bank.
package ofifo_pkg;

  function automatic int OFIFO_PTR_W(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a column can represent "exactly DEPTH entries".
  function automatic int OFIFO_CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned ofifo_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ofifo_col_buf.sv
// One column of the output FIFO bank: circular storage, pointers and occupancy count.
module ofifo_col_buf
  import ofifo_pkg::*;
#(
  parameter int BW    = 4,
  parameter int DEPTH = 16,
  localparam int PTR_W = OFIFO_PTR_W(DEPTH),
  localparam int CNT_W = OFIFO_CNT_W(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             pop,
  input  logic [BW-1:0]    din,
  output logic [BW-1:0]    dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BW-1:0]    mem_q [DEPTH];
  logic             wr_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  // A full column still accepts a write when the same edge pops a row.
  assign wr_en = wr & (~full | pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + PTR_W'(1);
    if (pop)   rptr_d = rptr_q + PTR_W'(1);
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/ofifo_multi.sv
// Output FIFO bank: COL column buffers with row-wide FWFT read.
// Optional sticky error flags enabled by defining OFIFO_MULTI_ERR_FLAGS_EN.
module ofifo_multi
  import ofifo_pkg::*;
#(
  parameter int COL          = 8,
  parameter int BW           = 4,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 14,
  localparam int CNT_W = OFIFO_CNT_W(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL-1:0]    wr,
  input  logic [COL*BW-1:0] in,
  input  logic              rd,
  output logic [COL*BW-1:0] out,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_full,
  output logic              o_afull,
  output logic [CNT_W-1:0]  o_level
`ifdef OFIFO_MULTI_ERR_FLAGS_EN
  ,
  output logic              o_overflow,
  output logic              o_underflow
`endif
);

  logic [BW-1:0]    head  [COL];
  logic [CNT_W-1:0] count [COL];
  logic [COL-1:0]   col_full;
  logic [COL-1:0]   col_empty;
  logic             pop;

  assign pop = rd & o_valid;

  for (genvar i = 0; i < COL; i++) begin : g_col
    ofifo_col_buf #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .pop   (pop),
      .din   (in[BW*i +: BW]),
      .dout  (head[i]),
      .count (count[i]),
      .full  (col_full[i]),
      .empty (col_empty[i])
    );
  end

  always_comb begin
    int unsigned lvl;
    lvl     = DEPTH;
    o_afull = 1'b0;
    out     = '0;
    for (int i = 0; i < COL; i++) begin
      lvl = ofifo_min(lvl, int'(count[i]));
      if (count[i] >= CNT_W'(AFULL_THRESH)) o_afull = 1'b1;
    end
    o_level = CNT_W'(lvl);
    o_valid = ~|col_empty;
    o_full  = |col_full;
    o_ready = ~&col_full;
    if (o_valid) begin
      for (int i = 0; i < COL; i++) out[BW*i +: BW] = head[i];
    end
  end

`ifdef OFIFO_MULTI_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A write is dropped only when its column is full and no row pops this edge.
  always_comb begin
    overflow_d  = overflow_q | (|(wr & col_full) & ~pop);
    underflow_d = underflow_q | (rd & ~o_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_ofifo_multi.sv
// Randomised and directed bench for ofifo_multi against a queue-based reference model.
module tb_ofifo_multi;

  localparam int COL   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [COL-1:0]    wr = '0;
  logic [COL*BW-1:0] in_d = '0;
  logic              rd = 1'b0;
  logic [COL*BW-1:0] out;
  logic              o_valid, o_ready, o_full, o_afull;
  logic [4:0]        o_level;
`ifdef OFIFO_MULTI_ERR_FLAGS_EN
  logic              o_overflow, o_underflow;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [BW-1:0] mq [COL][$];
  bit            m_ovf, m_unf;

  always #5 clk = ~clk;

  ofifo_multi #(.COL(COL), .BW(BW), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .in          (in_d),
    .rd          (rd),
    .out         (out),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_full      (o_full),
    .o_afull     (o_afull),
    .o_level     (o_level)
`ifdef OFIFO_MULTI_ERR_FLAGS_EN
    ,
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_valid();
    for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Applies the FIFO rules for one clock edge with the inputs that were sampled.
  task automatic model_edge(input bit rst, input logic [COL-1:0] w, input logic [COL*BW-1:0] d,
                            input logic r);
    bit pop_row;
    if (rst) begin
      for (int i = 0; i < COL; i++) mq[i].delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    pop_row = r && model_valid();
    if (r && !pop_row) m_unf = 1'b1;
    for (int i = 0; i < COL; i++) begin
      if (pop_row) void'(mq[i].pop_front());
      if (w[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[BW*i +: BW]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    bit                v;
    bit                f, rdy, af;
    int                mn;
    logic [COL*BW-1:0] eo;
    v = model_valid(); f = 0; rdy = 0; af = 0; mn = DEPTH; eo = '0;
    for (int i = 0; i < COL; i++) begin
      int sz;
      sz = mq[i].size();
      if (sz < mn) mn = sz;
      if (sz == DEPTH) f = 1; else rdy = 1;
      if (sz >= AFT) af = 1;
      if (v) eo[BW*i +: BW] = mq[i][0];
    end
    check("out",     64'(out),     64'(eo));
    check("o_valid", 64'(o_valid), 64'(v));
    check("o_ready", 64'(o_ready), 64'(rdy));
    check("o_full",  64'(o_full),  64'(f));
    check("o_afull", 64'(o_afull), 64'(af));
    check("o_level", 64'(o_level), 64'(mn));
`ifdef OFIFO_MULTI_ERR_FLAGS_EN
    check("o_overflow",  64'(o_overflow),  64'(m_ovf));
    check("o_underflow", 64'(o_underflow), 64'(m_unf));
`endif
  endtask

  // Drive inputs after a falling edge, let one rising edge happen, check at the next falling edge.
  task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    wr = w; in_d = d; rd = r;
    @(posedge clk);
    model_edge(reset, w, d, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step('0, '0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    step('0, '0, 1'b0);
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_ready", 64'(o_ready), 64'(1));
    check("rst_out",   64'(out),     64'(0));

    // One complete row, then pop it.
    step(8'hFF, 32'h7654_3210, 1'b0);
    check("row_out",   64'(out),     64'h7654_3210);
    check("row_level", 64'(o_level), 64'(1));
    step('0, '0, 1'b1);
    check("pop_valid", 64'(o_valid), 64'(0));
    check("pop_out",   64'(out),     64'(0));

    // Column 0 alone up to full, then one dropped write.
    for (int k = 0; k < DEPTH; k++) step(8'h01, 32'($urandom), 1'b0);
    check("c0_full",  64'(o_full),  64'(1));
    check("c0_afull", 64'(o_afull), 64'(1));
    check("c0_ready", 64'(o_ready), 64'(1));
    check("c0_valid", 64'(o_valid), 64'(0));
    step(8'h01, 32'h0000_000F, 1'b0);
`ifdef OFIFO_MULTI_ERR_FLAGS_EN
    check("c0_ovf", 64'(o_overflow), 64'(1));
`endif

    // Fill every column, then stream write+pop at full occupancy across the wrap.
    for (int k = 0; k < DEPTH; k++) step(8'hFF, 32'($urandom), 1'b0);
    check("all_full_ready", 64'(o_ready), 64'(0));
    check("all_full_level", 64'(o_level), 64'(DEPTH));
    for (int k = 0; k < 20; k++) begin
      logic [COL*BW-1:0] d;
      for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'(k + i);
      step(8'hFF, d, 1'b1);
    end
    check("stream_level", 64'(o_level), 64'(DEPTH));

    // Read while empty is ignored.
    do_reset();
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
`ifdef OFIFO_MULTI_ERR_FLAGS_EN
    check("unf_sticky", 64'(o_underflow), 64'(1));
`endif

    // Randomised traffic with varying write density and read rate.
    for (int seg = 0; seg < 12; seg++) begin
      int wp, rp;
      wp = $urandom_range(95, 10);
      rp = $urandom_range(95, 5);
      for (int k = 0; k < 80; k++) begin
        logic [COL-1:0] w;
        for (int i = 0; i < COL; i++) w[i] = ($urandom_range(99, 0) < wp);
        step(w, 32'($urandom), ($urandom_range(99, 0) < rp));
      end
    end

    // Reset mid-stream with wr and rd active wins.
    for (int k = 0; k < 5; k++) step(8'hFF, 32'($urandom), 1'b0);
    reset = 1'b1;
    step(8'hFF, 32'($urandom), 1'b1);
    reset = 1'b0;
    check("midrst_level", 64'(o_level), 64'(0));
    check("midrst_valid", 64'(o_valid), 64'(0));
    step('0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
